// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared registered ALU / branch comparator.
// One operation in flight; each takes IDLE -> EXEC -> CAPT -> RESP.
module alu_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid_0,
  output logic            req_ready_0,
  input  logic [2:0]      req_funct3_0,
  input  logic            req_alt_0,
  input  logic            req_br_0,
  input  logic [XLEN-1:0] req_x_0,
  input  logic [XLEN-1:0] req_y_0,
  input  logic            req_valid_1,
  output logic            req_ready_1,
  input  logic [2:0]      req_funct3_1,
  input  logic            req_alt_1,
  input  logic            req_br_1,
  input  logic [XLEN-1:0] req_x_1,
  input  logic [XLEN-1:0] req_y_1,
  output logic            rsp_valid_0,
  input  logic            rsp_ready_0,
  output logic [XLEN-1:0] rsp_data_0,
  output logic            rsp_valid_1,
  input  logic            rsp_ready_1,
  output logic [XLEN-1:0] rsp_data_1,
  output logic [2:0]      alu_funct3,
  output logic            alu_alt,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  input  logic [XLEN-1:0] alu_out,
  output logic [2:0]      cond_funct3,
  output logic [XLEN-1:0] cond_x,
  output logic [XLEN-1:0] cond_y,
  input  logic            cond_out,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t          r_state, w_nxt;
  logic            r_last, r_owner, r_alt, r_br;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_x, r_y, r_result;
  logic [15:0]     r_op_count;

  logic [1:0]      w_vld;
  logic            w_gnt, w_accept, w_rsp_rdy, w_rsp_hs;
  logic [XLEN-1:0] w_result;

  assign w_vld     = {req_valid_1, req_valid_0};
  // Both valid: the one not served last wins; otherwise the lone valid one.
  assign w_gnt     = (&w_vld) ? ~r_last : w_vld[1];
  assign w_accept  = (r_state == IDLE) && w_vld[w_gnt];
  assign w_rsp_rdy = r_owner ? rsp_ready_1 : rsp_ready_0;
  assign w_rsp_hs  = (r_state == RESP) && w_rsp_rdy;

  // funct3 010/011 have no branch meaning, so those compares return 0.
  always_comb begin
    w_result = alu_out;
    if (r_br)
      w_result = (r_funct3[2:1] == 2'b01) ? '0 : {{(XLEN-1){1'b0}}, cond_out};
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nxt = EXEC;
      EXEC:    w_nxt = CAPT;
      CAPT:    w_nxt = RESP;
      RESP:    if (w_rsp_hs) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_funct3   <= '0;
      r_alt      <= 1'b0;
      r_br       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_result   <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_gnt;
        r_funct3 <= w_gnt ? req_funct3_1 : req_funct3_0;
        r_alt    <= w_gnt ? req_alt_1    : req_alt_0;
        r_br     <= w_gnt ? req_br_1     : req_br_0;
        r_x      <= w_gnt ? req_x_1      : req_x_0;
        r_y      <= w_gnt ? req_y_1      : req_y_0;
      end
      if (r_state == CAPT) r_result <= w_result;
      if (w_rsp_hs) begin
        r_last <= r_owner;
        if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign req_ready_0 = (r_state == IDLE) && !w_gnt;
  assign req_ready_1 = (r_state == IDLE) &&  w_gnt;
  assign rsp_valid_0 = (r_state == RESP) && !r_owner;
  assign rsp_valid_1 = (r_state == RESP) &&  r_owner;
  assign rsp_data_0  = rsp_valid_0 ? r_result : '0;
  assign rsp_data_1  = rsp_valid_1 ? r_result : '0;

  assign alu_funct3  = r_funct3;
  assign alu_alt     = r_alt;
  assign alu_x       = r_x;
  assign alu_y       = r_y;
  assign cond_funct3 = r_funct3;
  assign cond_x      = r_x;
  assign cond_y      = r_y;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with behavioural registered ALU and comparator models.
module tb_alu_arb;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        req_valid_0 = 0, req_alt_0 = 0, req_br_0 = 0, rsp_ready_0 = 0;
  logic        req_valid_1 = 0, req_alt_1 = 0, req_br_1 = 0, rsp_ready_1 = 0;
  logic [2:0]  req_funct3_0 = 0, req_funct3_1 = 0;
  logic [31:0] req_x_0 = 0, req_y_0 = 0, req_x_1 = 0, req_y_1 = 0;
  logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, alu_alt, cond_out;
  logic [31:0] rsp_data_0, rsp_data_1, alu_x, alu_y, alu_out, cond_x, cond_y;
  logic [2:0]  alu_funct3, cond_funct3;
  logic [15:0] op_count;
  int          n_chk = 0, n_err = 0;

  alu_arb #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_funct3_0(req_funct3_0),
    .req_alt_0(req_alt_0), .req_br_0(req_br_0), .req_x_0(req_x_0), .req_y_0(req_y_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_funct3_1(req_funct3_1),
    .req_alt_1(req_alt_1), .req_br_1(req_br_1), .req_x_1(req_x_1), .req_y_1(req_y_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_data_0(rsp_data_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
    .alu_funct3(alu_funct3), .alu_alt(alu_alt), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
    .cond_funct3(cond_funct3), .cond_x(cond_x), .cond_y(cond_y), .cond_out(cond_out),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Registered execution units; 010/011 compare deliberately returns signed-less-than.
  always @(posedge clk) begin
    case (alu_funct3)
      3'b000:  alu_out <= alu_alt ? alu_x - alu_y : alu_x + alu_y;
      3'b001:  alu_out <= alu_x << alu_y[4:0];
      3'b010:  alu_out <= {31'b0, $signed(alu_x) < $signed(alu_y)};
      3'b011:  alu_out <= {31'b0, alu_x < alu_y};
      3'b100:  alu_out <= alu_x ^ alu_y;
      3'b101:  alu_out <= alu_alt ? 32'($signed(alu_x) >>> alu_y[4:0]) : alu_x >> alu_y[4:0];
      3'b110:  alu_out <= alu_x | alu_y;
      default: alu_out <= alu_x & alu_y;
    endcase
    case (cond_funct3)
      3'b000:  cond_out <= cond_x == cond_y;
      3'b001:  cond_out <= cond_x != cond_y;
      3'b101:  cond_out <= $signed(cond_x) >= $signed(cond_y);
      3'b110:  cond_out <= cond_x < cond_y;
      3'b111:  cond_out <= cond_x >= cond_y;
      default: cond_out <= $signed(cond_x) < $signed(cond_y);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] f3, input logic alt,
                         input logic br, input logic [31:0] x, input logic [31:0] y);
    if (i == 0) begin
      req_valid_0 = v; req_funct3_0 = f3; req_alt_0 = alt; req_br_0 = br; req_x_0 = x; req_y_0 = y;
    end else begin
      req_valid_1 = v; req_funct3_1 = f3; req_alt_1 = alt; req_br_1 = br; req_x_1 = x; req_y_1 = y;
    end
  endtask

  // Count negedges until the requester's rsp_valid rises; the bound guarantees termination.
  task automatic wait_rsp(input int i, output int cyc);
    cyc = 1;
    while (((i == 0) ? rsp_valid_0 : rsp_valid_1) !== 1'b1 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge after the response handshake.
  task automatic run_op(input int i, input logic [2:0] f3, input logic alt, input logic br,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp,
                        input logic [15:0] exp_cnt, input string tag);
    int cyc;
    set_req(i, 1'b1, f3, alt, br, x, y);
    if (i == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    #1 chk({tag, "_rdy"}, (i == 0) ? req_ready_0 : req_ready_1, 1);
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    wait_rsp(i, cyc);
    chk({tag, "_lat"}, cyc, 3);
    chk({tag, "_dat"}, (i == 0) ? rsp_data_0 : rsp_data_1, exp);
    @(negedge clk);
    chk({tag, "_cnt"}, {16'b0, op_count}, {16'b0, exp_cnt});
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cyc;
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hFFFFFFFE;
    exp_d[1] = 32'h1;

    // Reset values
    @(negedge clk);
    chk("rst_rv0", rsp_valid_0, 0);
    chk("rst_rv1", rsp_valid_1, 0);
    chk("rst_rd0", rsp_data_0, 0);
    chk("rst_rd1", rsp_data_1, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_alux", alu_x, 0);
    chk("rst_condy", cond_y, 0);
    chk("rst_f3", alu_funct3, 0);
    chk("rst_rdy", {req_ready_1, req_ready_0}, 2'b01);
    resetn = 1'b1;

    // ADD 5+7 accepted in the first IDLE cycle after release
    run_op(0, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 16'd1, "add");

    // Both valid continuously: grants alternate starting with requester 0
    pulse_reset();
    set_req(0, 1'b1, 3'b000, 1'b1, 1'b0, 32'd3, 32'd5);
    set_req(1, 1'b1, 3'b110, 1'b0, 1'b1, 32'd1, 32'd2);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_rdy", {req_ready_1, req_ready_0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      wait_rsp(k % 2, cyc);
      chk("rr_lat", cyc, 3);
      chk("rr_dat", (k % 2 == 0) ? rsp_data_0 : rsp_data_1, exp_d[k % 2]);
      chk("rr_other", (k % 2 == 0) ? {rsp_valid_1, rsp_data_1} : {rsp_valid_0, rsp_data_0}, 0);
      @(negedge clk);
      chk("rr_cnt", op_count, k + 1);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;

    // Backpressure on requester 1 while requester 0 waits
    set_req(1, 1'b1, 3'b100, 1'b0, 1'b0, 32'h0000F0F0, 32'h00000FF0);
    rsp_ready_1 = 1'b0;
    #1 chk("bp_rdy1", req_ready_1, 1);
    @(negedge clk);
    set_req(0, 1'b1, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
    rsp_ready_0 = 1'b1;
    req_x_1 = 32'hDEADBEEF;
    req_funct3_1 = 3'b111;
    wait_rsp(1, cyc);
    chk("bp_lat", cyc, 3);
    for (int k = 0; k < 10; k++) begin
      chk("bp_rv1", rsp_valid_1, 1);
      chk("bp_rd1", rsp_data_1, 32'h0000FF00);
      chk("bp_rdy0", req_ready_0, 0);
      chk("bp_rv0", rsp_valid_0, 0);
      @(negedge clk);
    end
    chk("bp_alux", alu_x, 32'h0000F0F0);
    chk("bp_aluf3", alu_funct3, 3'b100);
    chk("bp_condx", cond_x, 32'h0000F0F0);
    rsp_ready_1 = 1'b1;
    @(negedge clk);
    chk("bp_cnt", op_count, 5);
    chk("bp_gnt0", {req_ready_1, req_ready_0}, 2'b01);
    run_op(0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 16'd6, "bp_req0");

    // Branch corner cases and an ALU SLT for contrast
    run_op(0, 3'b010, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 16'd7, "br010");
    run_op(1, 3'b101, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 32'd0, 16'd8, "bge");
    run_op(0, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 16'd9, "slt");
    run_op(1, 3'b000, 1'b0, 1'b1, 32'd7, 32'd7, 32'd1, 16'd10, "beq");

    // Reset asserted during EXEC
    set_req(1, 1'b1, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4);
    rsp_ready_1 = 1'b1;
    #1 chk("mr_rdy1", req_ready_1, 1);
    @(negedge clk);
    req_valid_1 = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mr_rv", {rsp_valid_1, rsp_valid_0}, 0);
    chk("mr_rd1", rsp_data_1, 0);
    chk("mr_alux", alu_x, 0);
    chk("mr_condx", cond_x, 0);
    chk("mr_cnt", op_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mr_norsp", {rsp_valid_1, rsp_valid_0}, 0);
    end
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    #1 chk("mr_gnt0", {req_ready_1, req_ready_0}, 2'b01);
    req_valid_1 = 1'b0;
    run_op(0, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 16'd1, "mr_add");

    // Saturation of the response counter
    force dut.r_op_count = 16'hFFFE;
    #1 release dut.r_op_count;
    run_op(0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 16'hFFFF, "sat1");
    run_op(1, 3'b000, 1'b0, 1'b0, 32'd4, 32'd5, 32'd9, 16'hFFFF, "sat2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
